regfile_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the 32x32 2R1W register file. It buffers one pending access per requester and picks a winner each cycle. It drives the register file's EN/RD/WR/address/data pins and returns the registered Q1/Q2 read data to the requester that issued the access. Where the file's single write port and two read ports allow it, a read-only access and a write-only access from different requesters are merged into one cycle.

---
 rtl/regfile_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_regfile_port_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_arbiter.sv
// Two-requester arbiter/sequencer for a 32x32 2R1W register file.
// Define RFARB_FIXED_PRIO_EN for fixed A-over-B priority; default is round-robin.
module regfile_port_arbiter #(
    parameter int N = 32,
    parameter int M = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_a_req,
    output logic                   o_a_ready,
    input  logic                   i_a_rd,
    input  logic                   i_a_wr,
    input  logic [$clog2(M)-1:0]   i_a_r1,
    input  logic [$clog2(M)-1:0]   i_a_r2,
    input  logic [$clog2(M)-1:0]   i_a_rw,
    input  logic [N-1:0]           i_a_data,
    input  logic                   i_b_req,
    output logic                   o_b_ready,
    input  logic                   i_b_rd,
    input  logic                   i_b_wr,
    input  logic [$clog2(M)-1:0]   i_b_r1,
    input  logic [$clog2(M)-1:0]   i_b_r2,
    input  logic [$clog2(M)-1:0]   i_b_rw,
    input  logic [N-1:0]           i_b_data,
    output logic                   o_a_rsp_valid,
    output logic [N-1:0]           o_a_rsp_q1,
    output logic [N-1:0]           o_a_rsp_q2,
    output logic                   o_b_rsp_valid,
    output logic [N-1:0]           o_b_rsp_q1,
    output logic [N-1:0]           o_b_rsp_q2,
    output logic                   o_rf_EN,
    output logic                   o_rf_RD,
    output logic                   o_rf_WR,
    output logic [$clog2(M)-1:0]   o_rf_R1,
    output logic [$clog2(M)-1:0]   o_rf_R2,
    output logic [$clog2(M)-1:0]   o_rf_RW,
    output logic [N-1:0]           o_rf_Data_IN,
    input  logic [N-1:0]           i_rf_Q1,
    input  logic [N-1:0]           i_rf_Q2
);
    localparam int AW = $clog2(M);

    typedef struct packed {
        logic          rd;
        logic          wr;
        logic [AW-1:0] r1;
        logic [AW-1:0] r2;
        logic [AW-1:0] rw;
        logic [N-1:0]  data;
    } req_t;

    req_t         w_in [2];
    req_t         r_h  [2];
    logic [N-1:0] r_q1 [2];
    logic [N-1:0] r_q2 [2];
    logic [1:0]   w_req;
    logic [1:0]   r_hv;
    logic [1:0]   r_rv;
    logic [1:0]   r_rrd;
    logic [1:0]   w_ro;
    logic [1:0]   w_wo;
    logic [1:0]   w_iss;
    logic [1:0]   w_rdy;
    logic         w_both;
    logic         w_merge;
    logic         w_prio;
    logic         w_win;
    logic         w_rdr;
    logic         w_wtr;

    assign w_in[0] = {i_a_rd, i_a_wr, i_a_r1, i_a_r2, i_a_rw, i_a_data};
    assign w_in[1] = {i_b_rd, i_b_wr, i_b_r1, i_b_r2, i_b_rw, i_b_data};
    assign w_req   = {i_b_req, i_a_req};

    always_comb begin
        w_ro = '0;
        w_wo = '0;
        for (int i = 0; i < 2; i++) begin
            w_ro[i] = r_hv[i] & r_h[i].rd & ~r_h[i].wr;
            w_wo[i] = r_hv[i] & r_h[i].wr & ~r_h[i].rd;
        end
    end

    // A read-only and a write-only access fit the 2R1W file together.
    assign w_both  = &r_hv;
    assign w_merge = w_both & ((w_ro[0] & w_wo[1]) | (w_wo[0] & w_ro[1]));
    assign w_win   = w_both ? w_prio : r_hv[1];
    assign w_rdr   = w_ro[1];
    assign w_wtr   = ~w_rdr;
    assign w_iss   = w_merge ? 2'b11 : (r_hv & (w_win ? 2'b10 : 2'b01));
    assign w_rdy   = ~r_hv | w_iss;

`ifdef RFARB_FIXED_PRIO_EN
    assign w_prio = 1'b0;
`else
    logic r_ptr;

    assign w_prio = r_ptr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= 1'b0;
        end else if (w_both && !w_merge) begin
            r_ptr <= ~w_win;
        end
    end
`endif

    always_comb begin
        o_rf_EN      = 1'b0;
        o_rf_RD      = 1'b0;
        o_rf_WR      = 1'b0;
        o_rf_R1      = '0;
        o_rf_R2      = '0;
        o_rf_RW      = '0;
        o_rf_Data_IN = '0;
        if (w_merge) begin
            o_rf_EN      = 1'b1;
            o_rf_RD      = 1'b1;
            o_rf_WR      = 1'b1;
            o_rf_R1      = r_h[w_rdr].r1;
            o_rf_R2      = r_h[w_rdr].r2;
            o_rf_RW      = r_h[w_wtr].rw;
            o_rf_Data_IN = r_h[w_wtr].data;
        end else if (r_hv[w_win] && (r_h[w_win].rd || r_h[w_win].wr)) begin
            o_rf_EN      = 1'b1;
            o_rf_RD      = r_h[w_win].rd;
            o_rf_WR      = r_h[w_win].wr;
            o_rf_R1      = r_h[w_win].r1;
            o_rf_R2      = r_h[w_win].r2;
            o_rf_RW      = r_h[w_win].rw;
            o_rf_Data_IN = r_h[w_win].data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hv  <= '0;
            r_rv  <= '0;
            r_rrd <= '0;
            for (int i = 0; i < 2; i++) begin
                r_h[i]  <= '0;
                r_q1[i] <= '0;
                r_q2[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_req[i] && w_rdy[i]) begin
                    r_hv[i] <= 1'b1;
                    r_h[i]  <= w_in[i];
                end else if (w_iss[i]) begin
                    r_hv[i] <= 1'b0;
                end
                r_rv[i]  <= w_iss[i];
                r_rrd[i] <= w_iss[i] & r_h[i].rd;
                // Keep the last returned read data once the pulse ends.
                if (r_rv[i] && r_rrd[i]) begin
                    r_q1[i] <= i_rf_Q1;
                    r_q2[i] <= i_rf_Q2;
                end
            end
        end
    end

    assign o_a_ready     = w_rdy[0];
    assign o_b_ready     = w_rdy[1];
    assign o_a_rsp_valid = r_rv[0];
    assign o_b_rsp_valid = r_rv[1];
    assign o_a_rsp_q1    = (r_rv[0] & r_rrd[0]) ? i_rf_Q1 : r_q1[0];
    assign o_a_rsp_q2    = (r_rv[0] & r_rrd[0]) ? i_rf_Q2 : r_q2[0];
    assign o_b_rsp_q1    = (r_rv[1] & r_rrd[1]) ? i_rf_Q1 : r_q1[1];
    assign o_b_rsp_q2    = (r_rv[1] & r_rrd[1]) ? i_rf_Q2 : r_q2[1];

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter: directed scenarios plus random traffic
// against a transaction-level model; includes a behavioural 2R1W register file.
module tb_regfile_port_arbiter;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  rw;
        logic [31:0] data;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0] req = 2'b00;
    txn_t       stim [2];

    logic        a_ready, b_ready, a_rv, b_rv;
    logic [31:0] a_q1, a_q2, b_q1, b_q2;
    logic        rf_en, rf_rd, rf_wr;
    logic [4:0]  rf_r1, rf_r2, rf_rw;
    logic [31:0] rf_din;

    logic [31:0] rf_mem [32] = '{default: 32'h0};
    logic [31:0] rf_q1 = 32'h0;
    logic [31:0] rf_q2 = 32'h0;

    // Register file: reads see the pre-write contents of the same edge.
    always @(posedge clk) begin
        if (rf_en) begin
            if (rf_rd) begin
                rf_q1 <= rf_mem[rf_r1];
                rf_q2 <= rf_mem[rf_r2];
            end
            if (rf_wr) rf_mem[rf_rw] <= rf_din;
        end
    end

    regfile_port_arbiter #(.N(32), .M(32)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_a_req(req[0]), .o_a_ready(a_ready),
        .i_a_rd(stim[0].rd), .i_a_wr(stim[0].wr),
        .i_a_r1(stim[0].r1), .i_a_r2(stim[0].r2), .i_a_rw(stim[0].rw),
        .i_a_data(stim[0].data),
        .i_b_req(req[1]), .o_b_ready(b_ready),
        .i_b_rd(stim[1].rd), .i_b_wr(stim[1].wr),
        .i_b_r1(stim[1].r1), .i_b_r2(stim[1].r2), .i_b_rw(stim[1].rw),
        .i_b_data(stim[1].data),
        .o_a_rsp_valid(a_rv), .o_a_rsp_q1(a_q1), .o_a_rsp_q2(a_q2),
        .o_b_rsp_valid(b_rv), .o_b_rsp_q1(b_q1), .o_b_rsp_q2(b_q2),
        .o_rf_EN(rf_en), .o_rf_RD(rf_rd), .o_rf_WR(rf_wr),
        .o_rf_R1(rf_r1), .o_rf_R2(rf_r2), .o_rf_RW(rf_rw),
        .o_rf_Data_IN(rf_din),
        .i_rf_Q1(rf_q1), .i_rf_Q2(rf_q2)
    );

    // Transaction-level model state.
    bit          mpv [2];
    txn_t        mh  [2];
    int          mptr;
    logic [31:0] mmem [32];
    bit          mrv [2];
    bit          mrrd [2];
    logic [31:0] mq1 [2];
    logic [31:0] mq2 [2];
    logic [31:0] ml1 [2];
    logic [31:0] ml2 [2];
    bit          acc [2];

    bit          e_iss [2];
    bit          e_rdy [2];
    bit          e_both, e_merge;
    int          e_win;
    bit          e_en, e_rd, e_wr;
    logic [4:0]  e_r1, e_r2, e_rw;
    logic [31:0] e_data;

    int checks = 0;
    int errors = 0;
    bit rr_fixed;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mpv[i]  = 1'b0;
            mh[i]   = '0;
            mrv[i]  = 1'b0;
            mrrd[i] = 1'b0;
            mq1[i]  = '0;
            mq2[i]  = '0;
            ml1[i]  = '0;
            ml2[i]  = '0;
            acc[i]  = 1'b0;
        end
        mptr = 0;
    endtask

    task automatic model_comb();
        bit ro [2];
        bit wo [2];
        int prio;
        int rdr;
        if (rst) model_reset();
        for (int i = 0; i < 2; i++) begin
            ro[i] = mpv[i] && mh[i].rd && !mh[i].wr;
            wo[i] = mpv[i] && mh[i].wr && !mh[i].rd;
        end
        e_both  = mpv[0] && mpv[1];
        e_merge = e_both && ((ro[0] && wo[1]) || (wo[0] && ro[1]));
`ifdef RFARB_FIXED_PRIO_EN
        prio = 0;
`else
        prio = mptr;
`endif
        if (e_both) e_win = prio;
        else if (mpv[0]) e_win = 0;
        else if (mpv[1]) e_win = 1;
        else e_win = -1;
        e_iss[0] = 1'b0;
        e_iss[1] = 1'b0;
        if (e_merge) begin
            e_iss[0] = 1'b1;
            e_iss[1] = 1'b1;
        end else if (e_win >= 0) begin
            e_iss[e_win] = 1'b1;
        end
        e_en = 0; e_rd = 0; e_wr = 0;
        e_r1 = '0; e_r2 = '0; e_rw = '0; e_data = '0;
        if (e_merge) begin
            rdr = ro[0] ? 0 : 1;
            e_en = 1; e_rd = 1; e_wr = 1;
            e_r1 = mh[rdr].r1;
            e_r2 = mh[rdr].r2;
            e_rw = mh[1-rdr].rw;
            e_data = mh[1-rdr].data;
        end else if (e_win >= 0 && (mh[e_win].rd || mh[e_win].wr)) begin
            e_en = 1;
            e_rd = mh[e_win].rd;
            e_wr = mh[e_win].wr;
            e_r1 = mh[e_win].r1;
            e_r2 = mh[e_win].r2;
            e_rw = mh[e_win].rw;
            e_data = mh[e_win].data;
        end
        for (int i = 0; i < 2; i++) e_rdy[i] = !mpv[i] || e_iss[i];
    endtask

    task automatic model_seq();
        logic [31:0] n1 [2];
        logic [31:0] n2 [2];
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            n1[i] = mq1[i];
            n2[i] = mq2[i];
            if (e_iss[i] && mh[i].rd) begin
                n1[i] = mmem[mh[i].r1];
                n2[i] = mmem[mh[i].r2];
            end
            if (mrv[i] && mrrd[i]) begin
                ml1[i] = mq1[i];
                ml2[i] = mq2[i];
            end
        end
        for (int i = 0; i < 2; i++)
            if (e_iss[i] && mh[i].wr) mmem[mh[i].rw] = mh[i].data;
        for (int i = 0; i < 2; i++) begin
            mrv[i]  = e_iss[i];
            mrrd[i] = e_iss[i] && mh[i].rd;
            mq1[i]  = n1[i];
            mq2[i]  = n2[i];
        end
        if (e_both && !e_merge) mptr = 1 - e_win;
        for (int i = 0; i < 2; i++) begin
            acc[i] = req[i] && e_rdy[i];
            if (acc[i]) begin
                mpv[i] = 1'b1;
                mh[i]  = stim[i];
            end else if (e_iss[i]) begin
                mpv[i] = 1'b0;
            end
        end
    endtask

    task automatic cyc_cmp();
        @(negedge clk);
        model_comb();
        chk("a_ready", a_ready, e_rdy[0]);
        chk("b_ready", b_ready, e_rdy[1]);
        chk("rf_EN", rf_en, e_en);
        chk("rf_RD", rf_rd, e_rd);
        chk("rf_WR", rf_wr, e_wr);
        chk("rf_R1", rf_r1, e_r1);
        chk("rf_R2", rf_r2, e_r2);
        chk("rf_RW", rf_rw, e_rw);
        chk("rf_Data_IN", rf_din, e_data);
        chk("a_rsp_valid", a_rv, mrv[0]);
        chk("b_rsp_valid", b_rv, mrv[1]);
        chk("a_rsp_q1", a_q1, (mrv[0] && mrrd[0]) ? mq1[0] : ml1[0]);
        chk("a_rsp_q2", a_q2, (mrv[0] && mrrd[0]) ? mq2[0] : ml2[0]);
        chk("b_rsp_q1", b_q1, (mrv[1] && mrrd[1]) ? mq1[1] : ml1[1]);
        chk("b_rsp_q2", b_q2, (mrv[1] && mrrd[1]) ? mq2[1] : ml2[1]);
    endtask

    task automatic cyc_adv();
        @(posedge clk);
        model_seq();
        #1;
    endtask

    task automatic setq(input int i, input bit rq, input bit rd,
                        input bit wr, input int r1, input int r2,
                        input int rw, input logic [31:0] d);
        req[i]       = rq;
        stim[i].rd   = rd;
        stim[i].wr   = wr;
        stim[i].r1   = r1[4:0];
        stim[i].r2   = r2[4:0];
        stim[i].rw   = rw[4:0];
        stim[i].data = d;
    endtask

    task automatic rnd(input int i);
        req[i]       = ($urandom_range(0, 3) != 0);
        stim[i].rd   = $urandom_range(0, 1) != 0;
        stim[i].wr   = $urandom_range(0, 1) != 0;
        stim[i].r1   = 5'($urandom_range(0, 7));
        stim[i].r2   = 5'($urandom_range(0, 7));
        stim[i].rw   = 5'($urandom_range(0, 7));
        stim[i].data = $urandom;
    endtask

    initial begin
        stim[0] = '0;
        stim[1] = '0;
        model_reset();
        for (int k = 0; k < 32; k++) mmem[k] = '0;
`ifdef RFARB_FIXED_PRIO_EN
        rr_fixed = 1'b1;
`else
        rr_fixed = 1'b0;
`endif

        // Reset values
        cyc_cmp();
        chk("rst_a_ready", a_ready, 1);
        chk("rst_b_ready", b_ready, 1);
        chk("rst_rf_EN", rf_en, 0);
        cyc_adv();
        rst = 1'b0;

        // A reads r1=3 r2=7 from a cleared file
        setq(0, 1, 1, 0, 3, 7, 0, 0);
        cyc_cmp(); chk("t1_a_ready", a_ready, 1); cyc_adv();
        req[0] = 0;
        cyc_cmp(); chk("t1_rf_RD", rf_rd, 1); chk("t1_rf_R2", rf_r2, 7); cyc_adv();
        cyc_cmp(); chk("t1_a_rsp_valid", a_rv, 1); chk("t1_q1", a_q1, 0); cyc_adv();

        // Write reg5 then read it back
        setq(0, 1, 0, 1, 0, 0, 5, 32'hDEADBEEF);
        cyc_cmp(); cyc_adv();
        setq(0, 1, 1, 0, 5, 0, 0, 0);
        cyc_cmp(); chk("t2_rf_WR", rf_wr, 1); chk("t2_a_ready", a_ready, 1); cyc_adv();
        req[0] = 0;
        cyc_cmp(); chk("t2_rf_RD", rf_rd, 1); chk("t2_wr_rsp", a_rv, 1); cyc_adv();
        cyc_cmp(); chk("t2_rd_rsp", a_rv, 1); chk("t2_q1", a_q1, 32'hDEADBEEF); cyc_adv();

        // Merge: A reads reg5 while B writes reg5
        setq(0, 1, 1, 0, 5, 0, 0, 0);
        setq(1, 1, 0, 1, 0, 0, 5, 32'h1234);
        cyc_cmp(); cyc_adv();
        req = 2'b00;
        cyc_cmp();
        chk("m_rf_RD", rf_rd, 1); chk("m_rf_WR", rf_wr, 1);
        chk("m_rf_Data", rf_din, 32'h1234);
        cyc_adv();
        cyc_cmp();
        chk("m_a_rsp", a_rv, 1); chk("m_b_rsp", b_rv, 1);
        chk("m_a_q1_old", a_q1, 32'hDEADBEEF);
        cyc_adv();
        setq(0, 1, 1, 0, 5, 0, 0, 0);
        cyc_cmp(); cyc_adv();
        req[0] = 0;
        cyc_cmp(); cyc_adv();
        cyc_cmp(); chk("m_q1_new", a_q1, 32'h1234); cyc_adv();

        // Null request from B
        setq(1, 1, 0, 0, 1, 2, 3, 32'h55);
        cyc_cmp(); cyc_adv();
        req[1] = 0;
        cyc_cmp(); chk("n_rf_EN", rf_en, 0); cyc_adv();
        cyc_cmp(); chk("n_b_rsp", b_rv, 1); cyc_adv();
        cyc_cmp(); chk("n_b_rsp_end", b_rv, 0); cyc_adv();

        // Reset the cycle after an issue
        setq(0, 1, 1, 0, 5, 0, 0, 0);
        cyc_cmp(); cyc_adv();
        req[0] = 0;
        cyc_cmp(); chk("r_rf_EN", rf_en, 1); cyc_adv();
        rst = 1'b1;
        cyc_cmp(); chk("r_a_rsp", a_rv, 0); chk("r_a_q1", a_q1, 0); cyc_adv();
        rst = 1'b0;
        setq(0, 1, 1, 0, 5, 0, 0, 0);
        cyc_cmp(); cyc_adv();
        req[0] = 0;
        cyc_cmp(); cyc_adv();
        cyc_cmp(); chk("r_after_rsp", a_rv, 1); chk("r_after_q1", a_q1, 32'h1234); cyc_adv();

        // Contending write-only streams from A (reg1) and B (reg2)
        rst = 1'b1;
        cyc_cmp(); cyc_adv();
        rst = 1'b0;
        setq(0, 1, 0, 1, 0, 0, 1, 32'hA0);
        setq(1, 1, 0, 1, 0, 0, 2, 32'hB0);
        cyc_cmp(); cyc_adv();
        for (int k = 0; k < 4; k++) begin
            cyc_cmp();
            chk("rr_rf_RW", rf_rw, rr_fixed ? 1 : ((k % 2) ? 2 : 1));
            chk("rr_b_ready", b_ready, rr_fixed ? 0 : (k % 2));
            cyc_adv();
        end
        req = 2'b00;
        repeat (4) begin cyc_cmp(); cyc_adv(); end

        // Random traffic with occasional resets
        rnd(0);
        rnd(1);
        for (int c = 0; c < 3000; c++) begin
            cyc_cmp();
            cyc_adv();
            rst = ($urandom_range(0, 249) == 0);
            for (int i = 0; i < 2; i++)
                if (acc[i] || !req[i]) rnd(i);
        end
        rst = 1'b0;
        req = 2'b00;
        repeat (4) begin cyc_cmp(); cyc_adv(); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
